// File: rtl/pontos_pkg.sv
// Shared types and helpers for the score accumulator.
// Holds the FSM state enum, default widths, base table and saturating add.
package pontos_pkg;

  localparam int N_PLAYERS_D = 2;
  localparam int SCORE_W_D   = 8;
  localparam int ROUND_W_D   = 4;
  localparam int ERR_W_D     = 8;
  localparam int BASE_MAX_D  = 9;
  localparam int BONUS_MAX_D = 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    UPDATE
  } state_t;

  // Round 0 still earns one point; late rounds are capped.
  function automatic int unsigned base_pontos(
    input int unsigned r,
    input int unsigned bmax
  );
    if (r == 0) return 1;
    if (r > bmax) return bmax;
    return r;
  endfunction

  function automatic longint unsigned sat_add(
    input longint unsigned a,
    input longint unsigned b,
    input int unsigned     w
  );
    longint unsigned lim;
    longint unsigned sum;
    lim = (64'd1 << w) - 64'd1;
    sum = a + b;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/tabela_pontos_base.sv
// Combinational base-point lookup for a round number.
// Ports: rodada (round in), base (points out, SCORE_W bits).
module tabela_pontos_base
  import pontos_pkg::*;
#(
  parameter int ROUND_W  = ROUND_W_D,
  parameter int SCORE_W  = SCORE_W_D,
  parameter int BASE_MAX = BASE_MAX_D
) (
  input  logic [ROUND_W-1:0] rodada,
  output logic [SCORE_W-1:0] base
);

  assign base = SCORE_W'(base_pontos(32'(rodada), BASE_MAX));

endmodule

// File: rtl/acumulador_pontos.sv
// Registered multi-player score accumulator with valid/ready request.
// Ports: clock, reset_n, calc_valid/ready, jogador, rodada, erros, clear,
//        done, pontos_rodada, pontos_out, high_score, overflow.
module acumulador_pontos
  import pontos_pkg::*;
#(
  parameter int N_PLAYERS  = N_PLAYERS_D,
  parameter int SCORE_W    = SCORE_W_D,
  parameter int ROUND_W    = ROUND_W_D,
  parameter int ERR_W      = ERR_W_D,
  parameter int BASE_MAX   = BASE_MAX_D,
  parameter int BONUS_MAX  = BONUS_MAX_D,
  localparam int JW =
    (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           calc_valid,
  output logic                           calc_ready,
  input  logic [JW-1:0]                  jogador,
  input  logic [ROUND_W-1:0]             rodada,
  input  logic [ERR_W-1:0]               erros,
  input  logic                           clear,
  output logic                           done,
  output logic [SCORE_W-1:0]             pontos_rodada,
  output logic [N_PLAYERS*SCORE_W-1:0]   pontos_out,
  output logic [SCORE_W-1:0]             high_score,
  output logic [N_PLAYERS-1:0]           overflow
);

  localparam int SKW =
    (BONUS_MAX > 0) ? $clog2(BONUS_MAX + 1) : 1;
  localparam int CW =
    (ERR_W > SCORE_W) ? ERR_W : SCORE_W;

  if (N_PLAYERS < 1 || N_PLAYERS > 8) begin : g_np_chk
    $error("N_PLAYERS must be 1..8");
  end

  if (longint'(BASE_MAX + BONUS_MAX) >=
      (longint'(1) << SCORE_W)) begin : g_pts_chk
    $error("BASE_MAX+BONUS_MAX must fit SCORE_W");
  end

  state_t               state;
  logic [JW-1:0]        req_j;
  logic [ROUND_W-1:0]   req_r;
  logic [ERR_W-1:0]     req_e;
  logic [SCORE_W-1:0]   round_pts;
  logic [SCORE_W-1:0]   score  [N_PLAYERS];
  logic [SKW-1:0]       streak [N_PLAYERS];

  logic [SCORE_W-1:0]   base;
  logic [CW-1:0]        base_x;
  logic [CW-1:0]        err_x;
  logic [SCORE_W-1:0]   pen_pts;
  logic [SKW-1:0]       cur_streak;
  logic [SCORE_W-1:0]   bonus;
  logic [SCORE_W-1:0]   calc_pts;
  logic [SCORE_W:0]     sum;
  logic [SCORE_W-1:0]   new_score;
  logic                 sat_hit;
  logic [SKW-1:0]       streak_next;
  logic [SCORE_W-1:0]   new_high;
  logic [JW-1:0]        j_safe;
  logic                 clean;

  tabela_pontos_base #(
    .ROUND_W  (ROUND_W),
    .SCORE_W  (SCORE_W),
    .BASE_MAX (BASE_MAX)
  ) u_tabela (
    .rodada (req_r),
    .base   (base)
  );

  assign calc_ready = (state == IDLE) && !clear;

  assign j_safe =
    (32'(jogador) >= N_PLAYERS) ? '0 : jogador;

  // Compare in the wider of the two widths so
  // large error counts cannot alias small ones.
  assign base_x = CW'(base);
  assign err_x  = CW'(req_e);
  assign clean  = (req_e == '0);

  assign cur_streak = streak[req_j];

  always_comb begin
    pen_pts = '0;
    if (err_x < base_x)
      pen_pts = SCORE_W'(base_x - err_x);
  end

  always_comb begin
    bonus = '0;
    if (clean) begin
      if (32'(cur_streak) > BONUS_MAX)
        bonus = SCORE_W'(BONUS_MAX);
      else
        bonus = SCORE_W'(cur_streak);
    end
  end

  assign calc_pts = pen_pts + bonus;

  assign sum = {1'b0, score[req_j]} +
               {1'b0, round_pts};

  assign new_score = SCORE_W'(sat_add(
    64'(score[req_j]), 64'(round_pts), SCORE_W));

  // Saturation happened iff the clamped value
  // differs from the true sum.
  assign sat_hit = (sum != {1'b0, new_score});

  always_comb begin
    streak_next = '0;
    if (clean) begin
      if (32'(cur_streak) >= BONUS_MAX)
        streak_next = SKW'(BONUS_MAX);
      else
        streak_next = cur_streak + 1'b1;
    end
  end

  assign new_high =
    (new_score > high_score) ? new_score : high_score;

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_out
    assign pontos_out[p*SCORE_W +: SCORE_W] = score[p];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      req_j         <= '0;
      req_r         <= '0;
      req_e         <= '0;
      round_pts     <= '0;
      pontos_rodada <= '0;
      high_score    <= '0;
      overflow      <= '0;
      done          <= 1'b0;
      for (int p = 0; p < N_PLAYERS; p++) begin
        score[p]  <= '0;
        streak[p] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear) begin
            pontos_rodada <= '0;
            high_score    <= '0;
            overflow      <= '0;
            for (int p = 0; p < N_PLAYERS; p++) begin
              score[p]  <= '0;
              streak[p] <= '0;
            end
          end else if (calc_valid) begin
            req_j <= j_safe;
            req_r <= rodada;
            req_e <= erros;
            state <= CALC;
          end
        end
        CALC: begin
          round_pts <= calc_pts;
          state     <= UPDATE;
        end
        UPDATE: begin
          score[req_j]  <= new_score;
          streak[req_j] <= streak_next;
          if (sat_hit)
            overflow[req_j] <= 1'b1;
          pontos_rodada <= round_pts;
          high_score    <= new_high;
          done          <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acumulador_pontos.sv
// Directed testbench for acumulador_pontos.
// Default parameters: 2 players, 8-bit scores.
module tb_acumulador_pontos;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        calc_valid;
  logic        calc_ready;
  logic [0:0]  jogador;
  logic [3:0]  rodada;
  logic [7:0]  erros;
  logic        clear;
  logic        done;
  logic [7:0]  pontos_rodada;
  logic [15:0] pontos_out;
  logic [7:0]  high_score;
  logic [1:0]  overflow;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  acumulador_pontos dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .calc_valid    (calc_valid),
    .calc_ready    (calc_ready),
    .jogador       (jogador),
    .rodada        (rodada),
    .erros         (erros),
    .clear         (clear),
    .done          (done),
    .pontos_rodada (pontos_rodada),
    .pontos_out    (pontos_out),
    .high_score    (high_score),
    .overflow      (overflow)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one request from IDLE and samples done
  // at accept+1 and accept+2.
  task automatic do_round(
    input  logic [0:0] j,
    input  int         r,
    input  int         e,
    output logic       d1,
    output logic       d2
  );
    jogador    = j;
    rodada     = 4'(r);
    erros      = 8'(e);
    calc_valid = 1'b1;
    step();
    calc_valid = 1'b0;
    step();
    d1 = done;
    step();
    d2 = done;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    calc_valid = 1'b0;
    clear      = 1'b0;
    jogador    = '0;
    rodada     = '0;
    erros      = '0;
    step();
    step();
    reset_n = 1'b1;
    checks++;
    if (pontos_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_scores: got %h want 0000",
               pontos_out);
    end
    checks++;
    if ({done, pontos_rodada, high_score, overflow}
        !== 19'd0) begin
      errors++;
      $display("FAIL reset_regs: done=%b pts=%0d hi=%0d ovf=%b want 0",
               done, pontos_rodada, high_score, overflow);
    end
    checks++;
    if (calc_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", calc_ready);
    end
  endtask

  task automatic test_penalty();
    logic d1, d2;
    do_round(1'b0, 3, 1, d1, d2);
    checks++;
    if ({d1, d2} !== 2'b01) begin
      errors++;
      $display("FAIL latency: done@T+1,T+2 got %b%b want 01",
               d1, d2);
    end
    checks++;
    if (pontos_rodada !== 8'd2 || pontos_out[7:0] !== 8'd2) begin
      errors++;
      $display("FAIL pen_r3e1: pts=%0d score0=%0d want 2 2",
               pontos_rodada, pontos_out[7:0]);
    end
    do_round(1'b0, 3, 5, d1, d2);
    checks++;
    if (pontos_rodada !== 8'd0 || pontos_out[7:0] !== 8'd2) begin
      errors++;
      $display("FAIL pen_nowrap: pts=%0d score0=%0d want 0 2",
               pontos_rodada, pontos_out[7:0]);
    end
    do_round(1'b0, 3, 3, d1, d2);
    checks++;
    if (pontos_rodada !== 8'd0 || pontos_out[7:0] !== 8'd2) begin
      errors++;
      $display("FAIL pen_equal: pts=%0d score0=%0d want 0 2",
               pontos_rodada, pontos_out[7:0]);
    end
    // Streak 0 so far: clean round earns base only.
    do_round(1'b0, 3, 0, d1, d2);
    checks++;
    if (pontos_rodada !== 8'd3 || pontos_out[7:0] !== 8'd5) begin
      errors++;
      $display("FAIL pen_streak0: pts=%0d score0=%0d want 3 5",
               pontos_rodada, pontos_out[7:0]);
    end
  endtask

  task automatic test_streak();
    logic d1, d2;
    logic [7:0] want [6];
    logic [7:0] want_s [6];
    int         e_tab [6];
    want   = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd4, 8'd5};
    want_s = '{8'd5, 8'd11, 8'd18, 8'd26, 8'd30, 8'd35};
    e_tab  = '{0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      do_round(1'b1, 5, e_tab[i], d1, d2);
      checks++;
      if (d2 !== 1'b1 || pontos_rodada !== want[i] ||
          pontos_out[15:8] !== want_s[i]) begin
        errors++;
        $display("FAIL streak_%0d: done=%b pts=%0d score1=%0d want 1 %0d %0d",
                 i, d2, pontos_rodada, pontos_out[15:8],
                 want[i], want_s[i]);
      end
    end
    checks++;
    if (high_score !== 8'd35) begin
      errors++;
      $display("FAIL streak_high: got %0d want 35", high_score);
    end
  endtask

  task automatic test_saturation();
    logic d1, d2;
    int   n_done;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      do_round(1'b0, 9, 1, d1, d2);
      if (d2 === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 30 || pontos_out[7:0] !== 8'd245) begin
      errors++;
      $display("FAIL sat_ramp: dones=%0d score0=%0d want 30 245",
               n_done, pontos_out[7:0]);
    end
    do_round(1'b0, 6, 1, d1, d2);
    checks++;
    if (pontos_out[7:0] !== 8'd250 || overflow !== 2'b00) begin
      errors++;
      $display("FAIL sat_250: score0=%0d ovf=%b want 250 00",
               pontos_out[7:0], overflow);
    end
    do_round(1'b0, 9, 0, d1, d2);
    checks++;
    if (pontos_rodada !== 8'd9 || pontos_out[7:0] !== 8'd255 ||
        overflow !== 2'b01 || high_score !== 8'd255) begin
      errors++;
      $display("FAIL sat_hit: pts=%0d score0=%0d ovf=%b hi=%0d want 9 255 01 255",
               pontos_rodada, pontos_out[7:0], overflow, high_score);
    end
    do_round(1'b0, 9, 0, d1, d2);
    checks++;
    if (pontos_rodada !== 8'd10 || pontos_out[7:0] !== 8'd255 ||
        overflow !== 2'b01 || pontos_out[15:8] !== 8'd35) begin
      errors++;
      $display("FAIL sat_hold: pts=%0d score0=%0d ovf=%b score1=%0d want 10 255 01 35",
               pontos_rodada, pontos_out[7:0], overflow,
               pontos_out[15:8]);
    end
  endtask

  task automatic test_clear();
    clear      = 1'b1;
    calc_valid = 1'b1;
    jogador    = 1'b1;
    rodada     = 4'd5;
    erros      = 8'd0;
    #1;
    checks++;
    if (calc_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready: got %b want 0", calc_ready);
    end
    step();
    checks++;
    if (done !== 1'b0 || pontos_out !== 16'd0 ||
        high_score !== 8'd0 || overflow !== 2'b00 ||
        pontos_rodada !== 8'd0) begin
      errors++;
      $display("FAIL clr_zero: done=%b scores=%h hi=%0d ovf=%b pts=%0d want all 0",
               done, pontos_out, high_score, overflow, pontos_rodada);
    end
    step();
    clear      = 1'b0;
    calc_valid = 1'b0;
    step();
    step();
    checks++;
    if (done !== 1'b0 || calc_ready !== 1'b1 ||
        pontos_out !== 16'd0) begin
      errors++;
      $display("FAIL clr_noaccept: done=%b ready=%b scores=%h want 0 1 0000",
               done, calc_ready, pontos_out);
    end
  endtask

  task automatic test_base_edges();
    logic d1, d2;
    do_round(1'b0, 0, 0, d1, d2);
    checks++;
    if (pontos_rodada !== 8'd1 || pontos_out[7:0] !== 8'd1) begin
      errors++;
      $display("FAIL base_r0: pts=%0d score0=%0d want 1 1",
               pontos_rodada, pontos_out[7:0]);
    end
    do_round(1'b1, 15, 0, d1, d2);
    checks++;
    if (pontos_rodada !== 8'd9 || pontos_out[15:8] !== 8'd9) begin
      errors++;
      $display("FAIL base_r15: pts=%0d score1=%0d want 9 9",
               pontos_rodada, pontos_out[15:8]);
    end
    do_round(1'b0, 12, 0, d1, d2);
    checks++;
    if (pontos_rodada !== 8'd10 || pontos_out[7:0] !== 8'd11 ||
        high_score !== 8'd11) begin
      errors++;
      $display("FAIL base_r12: pts=%0d score0=%0d hi=%0d want 10 11 11",
               pontos_rodada, pontos_out[7:0], high_score);
    end
  endtask

  task automatic test_reset_mid();
    int n_done;
    n_done     = 0;
    jogador    = 1'b1;
    rodada     = 4'd5;
    erros      = 8'd0;
    calc_valid = 1'b1;
    step();
    calc_valid = 1'b0;
    reset_n    = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) n_done++;
      step();
    end
    checks++;
    if (n_done != 0 || pontos_out !== 16'd0 ||
        high_score !== 8'd0 || pontos_rodada !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid: dones=%0d scores=%h hi=%0d pts=%0d want 0",
               n_done, pontos_out, high_score, pontos_rodada);
    end
  endtask

  task automatic test_back_to_back();
    jogador    = 1'b0;
    rodada     = 4'd4;
    erros      = 8'd0;
    calc_valid = 1'b1;
    step();
    checks++;
    if (calc_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_calc: got %b want 0", calc_ready);
    end
    jogador = 1'b1;
    rodada  = 4'd2;
    step();
    checks++;
    if (calc_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_update: ready=%b done=%b want 0 0",
               calc_ready, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || pontos_rodada !== 8'd4 ||
        pontos_out[7:0] !== 8'd4) begin
      errors++;
      $display("FAIL b2b_first: done=%b pts=%0d score0=%0d want 1 4 4",
               done, pontos_rodada, pontos_out[7:0]);
    end
    step();
    calc_valid = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap1: done=%b want 0", done);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap2: done=%b want 0", done);
    end
    step();
    checks++;
    if (done !== 1'b1 || pontos_rodada !== 8'd2 ||
        pontos_out !== 16'h0204) begin
      errors++;
      $display("FAIL b2b_second: done=%b pts=%0d scores=%h want 1 2 0204",
               done, pontos_rodada, pontos_out);
    end
  endtask

  initial begin
    test_reset();
    test_penalty();
    test_streak();
    test_saturation();
    test_clear();
    test_base_edges();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/acumulador_pontos.md
Name: acumulador_pontos

Overview:
Clocked, multi-player score accumulator. It generalises the combinational per-round score calculator into a registered block with a handshake. It holds one running score per player and derives round points from a parametrised base table, minus errors clamped at zero, plus a clean-round streak bonus. Scores saturate, and a high-score register is kept. The game control FSM drives it once per completed round.

Parameters:
N_PLAYERS, 2, number of independent score channels (1..8)
SCORE_W, 8, width of each score and of high_score
ROUND_W, 4, width of rodada
ERR_W, 8, width of erros
BASE_MAX, 9, base-point ceiling; base(r) = 1 for r=0, r for 1..BASE_MAX, BASE_MAX above
BONUS_MAX, 3, streak bonus ceiling

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous reset, active-low
calc_valid  in  1  request a round update
calc_ready  out  1  block can accept a request (IDLE and clear low)
jogador  in  $clog2(N_PLAYERS) (min 1)  player index for the request
rodada  in  ROUND_W  round number
erros  in  ERR_W  errors in the round
clear  in  1  zero all scores, streaks, overflow and high_score
done  out  1  one-cycle pulse: update committed
pontos_rodada  out  SCORE_W  points awarded in the last committed update
pontos_out  out  N_PLAYERS*SCORE_W  all scores; player p at [p*SCORE_W +: SCORE_W]
high_score  out  SCORE_W  maximum score reached since reset/clear
overflow  out  N_PLAYERS  sticky per-player saturation flag

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; all scores, streaks, pontos_rodada, high_score and overflow = 0; done = 0.
  - Reset mid-operation aborts: no done, no score write.
- FSM:
  - IDLE: calc_ready = ~clear. If clear is high, zero the same registers as reset and stay in IDLE; calc_valid is not accepted. Else, on calc_valid, latch jogador/rodada/erros and go to CALC.
  - CALC: base = table(rodada), ERR_W-safe compare.
    - pen_pts = 0 if erros >= base, else base - erros.
    - bonus = (erros==0) ? min(streak[j], BONUS_MAX) : 0.
    - Register round_pts = pen_pts + bonus. Go to UPDATE.
  - UPDATE: sum = score[j] + round_pts, computed in SCORE_W+1 bits.
    - If sum > 2^SCORE_W-1: score[j] = all-ones, overflow[j] = 1. Else score[j] = sum.
    - streak[j] = (erros==0) ? min(streak[j]+1, BONUS_MAX) : 0.
    - pontos_rodada = round_pts; high_score = max(high_score, new score).
    - done = 1 for this cycle. Go to IDLE.
- Latency: accept at edge T; done is high in cycle T+2; scores and high_score are visible at T+2. Next accept is possible at T+3.
- calc_ready is low in CALC and UPDATE. calc_valid during those states is ignored; the requester must hold it.
- clear is ignored outside IDLE.
- jogador >= N_PLAYERS is treated as index 0.
- The subtraction never wraps: erros > base yields 0 round points, not a large value.
- Saturated scores stay at all-ones until clear or reset.
- round_pts never exceeds BASE_MAX + BONUS_MAX; elaboration asserts BASE_MAX+BONUS_MAX < 2^SCORE_W.

Decomposition:
- Shared package pontos_pkg holds:
  - State enum (IDLE, CALC, UPDATE).
  - Default widths.
  - Function base_pontos(rodada, BASE_MAX) implementing the table.
  - Function sat_add(a, b, W).
- One natural sub-module, tabela_pontos_base: a parametrised combinational base-point lookup (ROUND_W in, SCORE_W out) that replaces the fixed 16-entry table.
- Per-player register arrays stay in the top level.

Test Plan:
- Reset, then player 0, rodada=3, erros=1 -> done at accept+2, pontos_rodada=2, score0=2, streak0=0.
- Player 0, rodada=3, erros=5 -> pontos_rodada=0, score unchanged, no wrap; erros=3 (equal to base) -> also 0.
- Player 1, three rounds rodada=5 erros=0 -> pontos_rodada 5, 6, 7; score1=18; a fourth clean round gives 8 (bonus capped at 3); an erros=1 round then resets streak1 to 0.
- Bring score0 to 250, then rodada=9 erros=0 (bonus 0) -> score0=255, overflow[0]=1, high_score=255; a further round keeps 255.
- rodada=0 -> base 1; rodada=15 -> base 9 (erros=0, zero streak).
- calc_valid and clear together in IDLE -> clear wins, calc_ready=0, no done, all zero. reset_n low during CALC -> no done, all scores 0. calc_valid held during UPDATE -> accepted only at next IDLE.
